poly_voice_synth: RTL and testbench

//  Parametrised polyphonic square-wave synthesiser; successor to the fixed per-key tone toggles.

---
 rtl/piano_pkg.sv | 56 +++++
 rtl/voice_osc.sv | 56 +++++
 rtl/poly_voice_synth.sv | 176 +++++++++++++++++
 tb/tb_poly_voice_synth.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// piano_pkg: shared constants, event FSM encoding and the note pitch
// table (half periods in CLOCK_50 cycles) for poly_voice_synth.
package piano_pkg;

  localparam int DEF_NUM_NOTES = 24;
  localparam int DEF_HP_W      = 18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    COMMIT = 2'd2
  } evt_state_e;

  // round(25e6 / f), equal temperament with A4 (code 9) = 440 Hz
  function automatic logic [DEF_HP_W-1:0] half_period(
    input logic [4:0] code
  );
    logic [DEF_HP_W-1:0] hp;
    case (code)
      5'd0:    hp = 18'd95556;
      5'd1:    hp = 18'd90193;
      5'd2:    hp = 18'd85131;
      5'd3:    hp = 18'd80353;
      5'd4:    hp = 18'd75843;
      5'd5:    hp = 18'd71586;
      5'd6:    hp = 18'd67569;
      5'd7:    hp = 18'd63776;
      5'd8:    hp = 18'd60197;
      5'd9:    hp = 18'd56818;
      5'd10:   hp = 18'd53629;
      5'd11:   hp = 18'd50619;
      5'd12:   hp = 18'd47778;
      5'd13:   hp = 18'd45097;
      5'd14:   hp = 18'd42566;
      5'd15:   hp = 18'd40177;
      5'd16:   hp = 18'd37922;
      5'd17:   hp = 18'd35793;
      5'd18:   hp = 18'd33784;
      5'd19:   hp = 18'd31888;
      5'd20:   hp = 18'd30098;
      5'd21:   hp = 18'd28409;
      5'd22:   hp = 18'd26815;
      5'd23:   hp = 18'd25310;
      5'd24:   hp = 18'd23889;
      5'd25:   hp = 18'd22548;
      5'd26:   hp = 18'd21283;
      5'd27:   hp = 18'd20088;
      5'd28:   hp = 18'd18961;
      5'd29:   hp = 18'd17897;
      5'd30:   hp = 18'd16892;
      default: hp = 18'd15944;
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/voice_osc.sv
// voice_osc: one square-wave voice (half-period counter + level bit).
// Ports: load (start/retrigger), stop, hp, active, level.
module voice_osc
  import piano_pkg::*;
#(
  parameter int HP_W = DEF_HP_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            stop,
  input  logic [HP_W-1:0] hp,
  output logic            active,
  output logic            level
);

  logic            active_q, active_d;
  logic            level_q, level_d;
  logic [HP_W-1:0] cnt_q, cnt_d;

  always_comb begin
    active_d = active_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    if (load) begin
      active_d = 1'b1;
      level_d  = 1'b1;
      cnt_d    = hp - 1'b1;
    end else if (stop) begin
      active_d = 1'b0;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        level_d = ~level_q;
        cnt_d   = hp - 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      level_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
    end
  end

  assign active = active_q;
  assign level  = level_q;

endmodule

// File: rtl/poly_voice_synth.sv
// poly_voice_synth: note events -> voice allocation/stealing -> mixer.
// Ports: CLOCK_50/resetn, note_* handshake, sample_req/out/valid, voice flags.
module poly_voice_synth
  import piano_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int NUM_NOTES  = DEF_NUM_NOTES,
  parameter int NOTE_W     = 5,
  parameter int HP_W       = DEF_HP_W,
  parameter int SAMPLE_W   = 24,
  parameter int AMP        = 4096
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  note_valid,
  output logic                  note_ready,
  input  logic                  note_on,
  input  logic [NOTE_W-1:0]     note_code,
  input  logic                  sample_req,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  sample_valid,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [NUM_VOICES-1:0] tone_out
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int SUM_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam logic [NOTE_W:0] NOTE_LIM = (NOTE_W+1)'(NUM_NOTES);
  localparam logic signed [SUM_W-1:0] AMP_S = SUM_W'(AMP);
  localparam logic signed [SUM_W-1:0] SAT_HI =
    {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_LO =
    {{(SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  evt_state_e                         state_q, state_d;
  logic                               on_q, on_d;
  logic [NOTE_W-1:0]                  code_q, code_d;
  logic [NUM_VOICES-1:0]              match_q, match_d;
  logic [NUM_VOICES-1:0]              free_q, free_d;
  logic [VW-1:0]                      steal_q, steal_d;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]  note_q, note_d;
  logic [SAMPLE_W-1:0]                sample_q, sample_d;
  logic                               valid_q, valid_d;

  logic [NUM_VOICES-1:0]              active, level;
  logic [NUM_VOICES-1:0]              load, stop;
  logic [NUM_VOICES-1:0][HP_W-1:0]    hp_v;
  logic [HP_W-1:0]                    hp_evt;
  logic [VW-1:0]                      hit_idx, free_idx, tgt;
  logic                               in_range;
  logic signed [SUM_W-1:0]            sum;

  assign hp_evt   = HP_W'(half_period(5'(code_q)));
  assign in_range = {1'b0, code_q} < NOTE_LIM;

  // lowest set bit wins: scan downward, last hit is the lowest
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (match_q[i]) hit_idx = VW'(i);
      if (free_q[i])  free_idx = VW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    on_d    = on_q;
    code_d  = code_q;
    match_d = match_q;
    free_d  = free_q;
    steal_d = steal_q;
    note_d  = note_q;
    load    = '0;
    stop    = '0;
    tgt     = '0;
    unique case (state_q)
      IDLE: begin
        if (note_valid) begin
          on_d    = note_on;
          code_d  = note_code;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          match_d[i] = active[i] && (note_q[i] == code_q);
        end
        free_d  = ~active;
        state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if (in_range && on_q) begin
          if (|match_q) begin
            tgt = hit_idx;
          end else if (|free_q) begin
            tgt = free_idx;
          end else begin
            tgt     = steal_q;
            steal_d = (steal_q == VW'(NUM_VOICES - 1)) ?
                      '0 : steal_q + 1'b1;
          end
          load[tgt]   = 1'b1;
          note_d[tgt] = code_q;
        end else if (in_range) begin
          stop = match_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    // a loading voice must reload with the incoming note's period
    assign hp_v[g] = load[g] ? hp_evt :
                     HP_W'(half_period(5'(note_q[g])));

    voice_osc #(
      .HP_W (HP_W)
    ) u_osc (
      .clk    (CLOCK_50),
      .rst_n  (resetn),
      .load   (load[g]),
      .stop   (stop[g]),
      .hp     (hp_v[g]),
      .active (active[g]),
      .level  (level[g])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (active[i]) sum = level[i] ? sum + AMP_S : sum - AMP_S;
    end
    sample_d = sample_q;
    valid_d  = sample_req;
    if (sample_req) begin
      if (sum > SAT_HI)      sample_d = SAT_HI[SAMPLE_W-1:0];
      else if (sum < SAT_LO) sample_d = SAT_LO[SAMPLE_W-1:0];
      else                   sample_d = sum[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      on_q     <= 1'b0;
      code_q   <= '0;
      match_q  <= '0;
      free_q   <= '0;
      steal_q  <= '0;
      note_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      on_q     <= on_d;
      code_q   <= code_d;
      match_q  <= match_d;
      free_q   <= free_d;
      steal_q  <= steal_d;
      note_q   <= note_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign note_ready   = (state_q == IDLE);
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign voice_active = active;
  assign tone_out     = active & level;

endmodule

// File: tb/tb_poly_voice_synth.sv
// tb_poly_voice_synth: scoreboard bench for poly_voice_synth.
// dut_a: default 8 voices; dut_b: 4 voices, 14-bit samples, 32 notes.
module tb_poly_voice_synth;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  logic        a_valid, a_on, a_req;
  logic [4:0]  a_code;
  logic        a_ready, a_sv;
  logic [23:0] a_smp;
  logic [7:0]  a_act, a_tone;

  logic        b_valid, b_on, b_req;
  logic [4:0]  b_code;
  logic        b_ready, b_sv;
  logic [13:0] b_smp;
  logic [3:0]  b_act, b_tone;

  int     checks = 0;
  int     errors = 0;
  longint exp_a[$];
  longint exp_b[$];

  always #5 clk = ~clk;

  poly_voice_synth dut_a (
    .CLOCK_50     (clk),
    .resetn       (resetn),
    .note_valid   (a_valid),
    .note_ready   (a_ready),
    .note_on      (a_on),
    .note_code    (a_code),
    .sample_req   (a_req),
    .sample_out   (a_smp),
    .sample_valid (a_sv),
    .voice_active (a_act),
    .tone_out     (a_tone)
  );

  poly_voice_synth #(
    .NUM_VOICES (4),
    .NUM_NOTES  (32),
    .SAMPLE_W   (14),
    .AMP        (4096)
  ) dut_b (
    .CLOCK_50     (clk),
    .resetn       (resetn),
    .note_valid   (b_valid),
    .note_ready   (b_ready),
    .note_on      (b_on),
    .note_code    (b_code),
    .sample_req   (b_req),
    .sample_out   (b_smp),
    .sample_valid (b_sv),
    .voice_active (b_act),
    .tone_out     (b_tone)
  );

  task automatic chk(input string tag,
                     input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_sv) begin
      if (exp_a.size() == 0) chk("a_spurious_valid", 1, 0);
      else chk("a_sample", $signed(a_smp), exp_a.pop_front());
    end
    if (b_sv) begin
      if (exp_b.size() == 0) chk("b_spurious_valid", 1, 0);
      else chk("b_sample", $signed(b_smp), exp_b.pop_front());
    end
  end

  // returns on the negedge after the COMMIT edge
  task automatic send(input bit sel, input bit on, input int code);
    int n;
    @(negedge clk);
    if (sel) begin
      b_valid = 1'b1; b_on = on; b_code = 5'(code);
    end else begin
      a_valid = 1'b1; a_on = on; a_code = 5'(code);
    end
    n = 0;
    while (!(sel ? b_ready : a_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", n, 0);
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic sample(input bit sel, input longint exp);
    @(negedge clk);
    if (sel) begin
      b_req = 1'b1; exp_b.push_back(exp);
    end else begin
      a_req = 1'b1; exp_a.push_back(exp);
    end
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clk);
    if (sel) chk("b_latency", exp_b.size(), 0);
    else     chk("a_latency", exp_a.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    a_valid = 0; a_on = 0; a_code = 0; a_req = 0;
    b_valid = 0; b_on = 0; b_code = 0; b_req = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", a_ready, 1);
    chk("rst_act", a_act, 0);
    chk("rst_tone", a_tone, 0);
    chk("rst_sv", a_sv, 0);
    chk("rst_smp", a_smp, 0);
    chk("rst_b_act", b_act, 0);
    resetn = 1'b1;

    // note-on A4: latency and first toggle
    @(negedge clk);
    a_valid = 1; a_on = 1; a_code = 9;
    @(posedge clk);
    @(negedge clk);
    a_valid = 0;
    chk("t1_busy", a_ready, 0);
    @(negedge clk);
    chk("t1_early", a_act, 0);
    @(negedge clk);
    chk("t1_act", a_act, 8'h01);
    chk("t1_ready", a_ready, 1);
    chk("t1_tone", a_tone, 8'h01);
    k = 0;
    while (k < 60000) begin
      @(negedge clk);
      k++;
      if (a_tone[0] == 1'b0) break;
    end
    chk("t1_half_period", k, 56818);
    chk("t1_still_act", a_act, 8'h01);
    sample(0, -4096);

    // retrigger same note: same voice, phase restarts high
    send(0, 1, 9);
    chk("t4_act", a_act, 8'h01);
    chk("t4_phase", a_tone, 8'h01);
    sample(0, 4096);
    send(0, 0, 9);
    chk("t4_off", a_act, 8'h00);
    sample(0, 0);

    // allocation and note-off
    send(0, 1, 0);
    send(0, 1, 4);
    send(0, 1, 7);
    chk("t2_act", a_act, 8'h07);
    sample(0, 12288);
    send(0, 0, 4);
    chk("t2_off4", a_act, 8'h05);
    send(0, 1, 2);
    chk("t2_reuse", a_act, 8'h07);
    send(0, 0, 2);
    chk("t2_slot1", a_act, 8'h05);
    send(0, 0, 0);
    send(0, 0, 7);
    chk("t2_clear", a_act, 8'h00);

    // stealing
    for (int c = 10; c < 18; c++) send(0, 1, c);
    chk("t3_full", a_act, 8'hff);
    send(0, 1, 18);
    chk("t3_steal0", a_act, 8'hff);
    send(0, 0, 10);
    chk("t3_gone10", a_act, 8'hff);
    send(0, 1, 19);
    send(0, 0, 11);
    chk("t3_gone11", a_act, 8'hff);
    send(0, 0, 19);
    chk("t3_steal1", a_act, 8'hfd);
    send(0, 0, 18);
    chk("t3_v0", a_act, 8'hfc);
    send(0, 1, 24);
    chk("oor_on", a_act, 8'hfc);
    send(0, 0, 30);
    chk("oor_off", a_act, 8'hfc);
    sample(0, 24576);

    // saturation on the narrow instance
    for (int c = 28; c < 32; c++) send(1, 1, c);
    chk("t5_act", b_act, 4'hf);
    chk("t5_high", b_tone, 4'hf);
    sample(1, 8191);
    repeat (19100) @(negedge clk);
    chk("t5_low", b_tone, 4'h0);
    chk("t5_act2", b_act, 4'hf);
    sample(1, -8192);

    // reset during LOOKUP with note_valid held
    @(negedge clk);
    a_valid = 1; a_on = 1; a_code = 5;
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_ready", a_ready, 1);
    chk("t6_act", a_act, 0);
    chk("t6_tone", a_tone, 0);
    chk("t6_smp", a_smp, 0);
    chk("t6_sv", a_sv, 0);
    chk("t6_b_act", b_act, 0);
    @(negedge clk);
    @(negedge clk);
    a_valid = 0;
    resetn = 1'b1;
    @(negedge clk);
    chk("t6_ready_rel", a_ready, 1);
    repeat (5) @(negedge clk);
    chk("t6_lost", a_act, 0);
    send(0, 1, 3);
    chk("t6_recover", a_act, 8'h01);

    repeat (3) @(negedge clk);
    chk("a_queue_end", exp_a.size(), 0);
    chk("b_queue_end", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
